// File: rtl/img_proc_axil_regs.sv
// AXI4-Lite register bank for the image processor S00_AXI port: CTRL/IMG_SIZE/PARAM/STATUS.
// Optional macro IMGPROC_AXIL_SLVERR_EN enables SLVERR for out-of-range accesses and STATUS writes.
module img_proc_axil_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] CTRL_RESET         = 32'h0000_0000
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [31:0]                       cfg_ctrl,
    output logic [31:0]                       cfg_size,
    output logic [31:0]                       cfg_param,
    output logic                              start_pulse,
    input  logic [31:0]                       status_in
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic        aw_full_q, aw_full_d;
    logic [1:0]  aw_idx_q, aw_idx_d;
    logic        aw_oor_q, aw_oor_d;
    logic        awready_q, awready_d;
    logic        w_full_q, w_full_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] size_q, size_d;
    logic [31:0] param_q, param_d;
    logic        start_q, start_d;
    logic        ar_pend_q, ar_pend_d;
    logic [1:0]  ar_idx_q, ar_idx_d;
    logic        ar_oor_q, ar_oor_d;
    logic [31:0] status_snap_q, status_snap_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        commit_s;
    logic        wr_err_s;
    logic        aw_oor_s;
    logic        ar_oor_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Address range decode and write-error classification
    always_comb begin
        aw_oor_s = 1'b0;
        ar_oor_s = 1'b0;
        wr_err_s = 1'b0;
`ifdef IMGPROC_AXIL_SLVERR_EN
        aw_oor_s = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
        ar_oor_s = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
        wr_err_s = aw_oor_q || (aw_idx_q == 2'd3);
`else
        aw_oor_s = 1'b0;
        ar_oor_s = 1'b0;
        wr_err_s = 1'b0;
`endif
    end

    // Write path: AW/W buffers, commit into registers, B response
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        aw_oor_d  = aw_oor_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        size_d    = size_q;
        param_d   = param_q;
        start_d   = 1'b0;
        commit_s  = aw_full_q && w_full_q && !bvalid_q;

        // Handshake needs an empty buffer and commit needs a full one, so they never collide.
        if (S_AXI_AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[3:2];
            aw_oor_d  = aw_oor_s;
        end else if (commit_s) begin
            aw_full_d = 1'b0;
        end else begin
            aw_full_d = aw_full_q;
        end

        if (S_AXI_WVALID && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA[31:0];
            w_strb_d = S_AXI_WSTRB[3:0];
        end else if (commit_s) begin
            w_full_d = 1'b0;
        end else begin
            w_full_d = w_full_q;
        end

        if (commit_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err_s ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        if (commit_s && !wr_err_s) begin
            case (aw_idx_q)
                2'd0: begin
                    ctrl_d  = wstrb_merge(ctrl_q, w_data_q, w_strb_q) & 32'hFFFF_FFFE;
                    start_d = w_strb_q[0] && w_data_q[0];
                end
                2'd1:    size_d  = wstrb_merge(size_q, w_data_q, w_strb_q);
                2'd2:    param_d = wstrb_merge(param_q, w_data_q, w_strb_q);
                default: start_d = 1'b0;
            endcase
        end else begin
            start_d = 1'b0;
        end

        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
    end

    // Read data selection from the current (pre-commit) register values
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (ar_idx_q)
            2'd0:    rd_mux_s = ctrl_q;
            2'd1:    rd_mux_s = size_q;
            2'd2:    rd_mux_s = param_q;
            default: rd_mux_s = status_snap_q;
        endcase
    end

    // Read path: AR capture, one-cycle lookup, R response hold
    always_comb begin
        ar_pend_d     = ar_pend_q;
        ar_idx_d      = ar_idx_q;
        ar_oor_d      = ar_oor_q;
        status_snap_d = status_snap_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;

        if (S_AXI_ARVALID && arready_q) begin
            ar_pend_d     = 1'b1;
            ar_idx_d      = S_AXI_ARADDR[3:2];
            ar_oor_d      = ar_oor_s;
            status_snap_d = status_in;
        end else if (ar_pend_q) begin
            ar_pend_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = ar_oor_q ? 32'h0000_0000 : rd_mux_s;
            rresp_d   = ar_oor_q ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end

        arready_d = !rvalid_d && !ar_pend_d;
    end

    // State registers; reset discards any buffered or pending transaction
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_q     <= 1'b0;
            aw_idx_q      <= 2'd0;
            aw_oor_q      <= 1'b0;
            awready_q     <= 1'b0;
            w_full_q      <= 1'b0;
            w_data_q      <= 32'h0000_0000;
            w_strb_q      <= 4'h0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            ctrl_q        <= CTRL_RESET & 32'hFFFF_FFFE;
            size_q        <= 32'h0000_0000;
            param_q       <= 32'h0000_0000;
            start_q       <= 1'b0;
            ar_pend_q     <= 1'b0;
            ar_idx_q      <= 2'd0;
            ar_oor_q      <= 1'b0;
            status_snap_q <= 32'h0000_0000;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'h0000_0000;
            rresp_q       <= 2'b00;
        end else begin
            aw_full_q     <= aw_full_d;
            aw_idx_q      <= aw_idx_d;
            aw_oor_q      <= aw_oor_d;
            awready_q     <= awready_d;
            w_full_q      <= w_full_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            ctrl_q        <= ctrl_d;
            size_q        <= size_d;
            param_q       <= param_d;
            start_q       <= start_d;
            ar_pend_q     <= ar_pend_d;
            ar_idx_q      <= ar_idx_d;
            ar_oor_q      <= ar_oor_d;
            status_snap_q <= status_snap_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign cfg_ctrl      = ctrl_q;
    assign cfg_size      = size_q;
    assign cfg_param     = param_q;
    assign start_pulse   = start_q;

endmodule
